// File: rtl/lvt_port_frontend_pkg.sv
// Shared types and default sizes for the LVT memory request front-end.
package lvt_fe_pkg;

  localparam int unsigned DefAddrWidth = 7;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefReqDepth  = 4;
  localparam int unsigned DefRespDepth = 4;

  typedef enum logic {GNT_WR, GNT_RD} gnt_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefDataWidth-1:0] data;
  } wr_req_t;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
  } rd_req_t;

endpackage

// File: rtl/lvt_port_frontend_if.sv
// Client-side request/response streams of the LVT front-end.
interface lvt_port_frontend_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  w0_valid;
  logic                  w0_ready;
  logic [ADDR_WIDTH-1:0] w0_addr;
  logic [DATA_WIDTH-1:0] w0_data;
  logic                  w1_valid;
  logic                  w1_ready;
  logic [ADDR_WIDTH-1:0] w1_addr;
  logic [DATA_WIDTH-1:0] w1_data;
  logic                  r_valid;
  logic                  r_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    output w0_valid, w0_addr, w0_data, w1_valid, w1_addr, w1_data, r_valid, r_addr, resp_ready,
    input  w0_ready, w1_ready, r_ready, resp_valid, resp_data
  );

  modport slave (
    input  w0_valid, w0_addr, w0_data, w1_valid, w1_addr, w1_data, r_valid, r_addr, resp_ready,
    output w0_ready, w1_ready, r_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/lvt_port_frontend_fifo.sv
// Synchronous FIFO (lvt_fe_fifo) with wrap-bit pointers; push ignored when full, pop when empty.
module lvt_fe_fifo #(
  parameter  int unsigned Width = 8,
  parameter  int unsigned Depth = 4,
  localparam int unsigned PtrW  = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PtrW:0]    count
);

  localparam logic [PtrW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign count   = wptr_q - rptr_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lvt_port_frontend.sv
// Buffers two write streams and one read stream and schedules them onto the LVT memory pins.
// Define LVT_FE_COLLISION_SERIALIZE_EN to split same-address dual writes across two grants.
module lvt_port_frontend
  import lvt_fe_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned REQ_DEPTH  = DefReqDepth,
  parameter int unsigned RESP_DEPTH = DefRespDepth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lvt_port_frontend_if.slave    bus,
  output logic                  wr0_en,
  output logic [ADDR_WIDTH-1:0] wr0_addr,
  output logic [DATA_WIDTH-1:0] wr0_data,
  output logic                  wr1_en,
  output logic [ADDR_WIDTH-1:0] wr1_addr,
  output logic [DATA_WIDTH-1:0] wr1_data,
  output logic                  rd0_en,
  output logic [ADDR_WIDTH-1:0] rd0_addr,
  input  logic [DATA_WIDTH-1:0] rd0_data
);

  localparam int unsigned ReqCntW  = $clog2(REQ_DEPTH) + 1;
  localparam int unsigned RespCntW = $clog2(RESP_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_ent_t;

  logic                  init_q, cap_q;
  logic [1:0]            inflight_q, inflight_d;
  gnt_e                  last_gnt_q, last_gnt_d;
  wr_ent_t               w0_head, w1_head;
  logic [ADDR_WIDTH-1:0] r_head;
  logic                  w0_full, w1_full, r_full, resp_full;
  logic                  w0_empty, w1_empty, r_empty, resp_empty;
  logic [ReqCntW-1:0]    w0_cnt, w1_cnt, r_cnt;
  logic [RespCntW-1:0]   resp_cnt;
  logic                  rd_elig, wr_elig, gnt_rd, gnt_wr, pop_w0, pop_w1;
  logic                  unused_sig;

  // Readies stay low until the first edge after reset release.
  assign bus.w0_ready   = init_q & ~w0_full;
  assign bus.w1_ready   = init_q & ~w1_full;
  assign bus.r_ready    = init_q & ~r_full;
  assign bus.resp_valid = ~resp_empty;
  assign unused_sig     = ^{w0_cnt, w1_cnt, r_cnt, resp_full};

  lvt_fe_fifo #(.Width(ADDR_WIDTH + DATA_WIDTH), .Depth(REQ_DEPTH)) u_w0_fifo (
    .clk(clk), .rst_n(rst_n), .push(bus.w0_valid & bus.w0_ready),
    .wdata({bus.w0_addr, bus.w0_data}), .pop(pop_w0), .rdata(w0_head),
    .full(w0_full), .empty(w0_empty), .count(w0_cnt)
  );

  lvt_fe_fifo #(.Width(ADDR_WIDTH + DATA_WIDTH), .Depth(REQ_DEPTH)) u_w1_fifo (
    .clk(clk), .rst_n(rst_n), .push(bus.w1_valid & bus.w1_ready),
    .wdata({bus.w1_addr, bus.w1_data}), .pop(pop_w1), .rdata(w1_head),
    .full(w1_full), .empty(w1_empty), .count(w1_cnt)
  );

  lvt_fe_fifo #(.Width(ADDR_WIDTH), .Depth(REQ_DEPTH)) u_r_fifo (
    .clk(clk), .rst_n(rst_n), .push(bus.r_valid & bus.r_ready),
    .wdata(bus.r_addr), .pop(gnt_rd), .rdata(r_head),
    .full(r_full), .empty(r_empty), .count(r_cnt)
  );

  lvt_fe_fifo #(.Width(DATA_WIDTH), .Depth(RESP_DEPTH)) u_resp_fifo (
    .clk(clk), .rst_n(rst_n), .push(cap_q),
    .wdata(rd0_data), .pop(bus.resp_valid & bus.resp_ready), .rdata(bus.resp_data),
    .full(resp_full), .empty(resp_empty), .count(resp_cnt)
  );

  always_comb begin
    // Reads in flight reserve response slots so capture can never overflow.
    rd_elig    = ~r_empty && ((32'(resp_cnt) + 32'(inflight_q)) < RESP_DEPTH);
    wr_elig    = ~w0_empty | ~w1_empty;
    gnt_rd     = rd_elig && (!wr_elig || last_gnt_q == GNT_WR);
    gnt_wr     = wr_elig && !gnt_rd;
    pop_w0     = gnt_wr & ~w0_empty;
`ifdef LVT_FE_COLLISION_SERIALIZE_EN
    pop_w1     = gnt_wr & ~w1_empty & ~(~w0_empty && (w0_head.addr == w1_head.addr));
`else
    pop_w1     = gnt_wr & ~w1_empty;
`endif
    last_gnt_d = last_gnt_q;
    if (gnt_rd)      last_gnt_d = GNT_RD;
    else if (gnt_wr) last_gnt_d = GNT_WR;
    inflight_d = inflight_q + 2'(gnt_rd) - 2'(cap_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      cap_q      <= 1'b0;
      inflight_q <= '0;
      last_gnt_q <= GNT_WR;
      wr0_en     <= 1'b0;
      wr0_addr   <= '0;
      wr0_data   <= '0;
      wr1_en     <= 1'b0;
      wr1_addr   <= '0;
      wr1_data   <= '0;
      rd0_en     <= 1'b0;
      rd0_addr   <= '0;
    end else begin
      init_q     <= 1'b1;
      cap_q      <= rd0_en;
      inflight_q <= inflight_d;
      last_gnt_q <= last_gnt_d;
      wr0_en     <= pop_w0;
      wr1_en     <= pop_w1;
      rd0_en     <= gnt_rd;
      if (pop_w0) begin
        wr0_addr <= w0_head.addr;
        wr0_data <= w0_head.data;
      end
      if (pop_w1) begin
        wr1_addr <= w1_head.addr;
        wr1_data <= w1_head.data;
      end
      if (gnt_rd) rd0_addr <= r_head;
    end
  end

endmodule

// File: tb/tb_lvt_port_frontend.sv
// Directed bench for lvt_port_frontend with a behavioural model of the LVT memory.
module tb_lvt_port_frontend;
  import lvt_fe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wr0_en, wr1_en, rd0_en;
  logic [6:0]  wr0_addr, wr1_addr, rd0_addr;
  logic [31:0] wr0_data, wr1_data, rd0_data;
  logic [31:0] mem_model [128];

  int checks = 0;
  int failures = 0;
  int collisions = 0;
  int alt_gaps = 0;
  int alt_repeats = 0;
  int rd_issued = 0;
  logic prev_rd = 1'b0;
  logic have_prev = 1'b0;
  logic mon_alt = 1'b0;
  logic mon_log = 1'b0;
  logic [31:0] wr0_log [$];
  logic [31:0] wexp [$];

  lvt_port_frontend_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) bus ();

  lvt_port_frontend #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .REQ_DEPTH(4), .RESP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: port 1 wins a same-address dual write; read data one cycle after rd0_en.
  always @(posedge clk) begin
    if (wr0_en) mem_model[wr0_addr] <= wr0_data;
    if (wr1_en) mem_model[wr1_addr] <= wr1_data;
    if (rd0_en) rd0_data <= mem_model[rd0_addr];
  end

  always @(negedge clk) begin
    if (rd0_en && (wr0_en || wr1_en)) collisions <= collisions + 1;
    if (rd0_en) rd_issued <= rd_issued + 1;
    if (mon_alt) begin
      if (!(rd0_en || wr0_en || wr1_en)) alt_gaps <= alt_gaps + 1;
      else begin
        if (have_prev && (rd0_en == prev_rd)) alt_repeats <= alt_repeats + 1;
        prev_rd   <= rd0_en;
        have_prev <= 1'b1;
      end
    end
    if (mon_log && wr0_en) wr0_log.push_back(wr0_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_w0(input logic [6:0] a, input logic [31:0] d);
    bus.w0_valid = 1'b1;
    bus.w0_addr  = a;
    bus.w0_data  = d;
    for (int t = 0; t < 30 && !bus.w0_ready; t++) step();
    chk("push_w0_ready", bus.w0_ready, 1);
    step();
    bus.w0_valid = 1'b0;
  endtask

  task automatic push_r(input logic [6:0] a);
    bus.r_valid = 1'b1;
    bus.r_addr  = a;
    for (int t = 0; t < 30 && !bus.r_ready; t++) step();
    chk("push_r_ready", bus.r_ready, 1);
    step();
    bus.r_valid = 1'b0;
  endtask

  initial begin
    int got;
    int rd_base;
    int nxt;
    int hits;
    logic saw_full;

    rst_n = 1'b0;
    bus.w0_valid = 1'b0; bus.w0_addr = '0; bus.w0_data = '0;
    bus.w1_valid = 1'b0; bus.w1_addr = '0; bus.w1_data = '0;
    bus.r_valid = 1'b0;  bus.r_addr = '0;  bus.resp_ready = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_w0_ready", bus.w0_ready, 0);
    chk("rst_r_ready", bus.r_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_en", {wr0_en, wr1_en, rd0_en}, 0);
    chk("rst_addr", {wr0_addr, wr1_addr, rd0_addr}, 0);
    chk("rst_data", {wr0_data, wr1_data}, 0);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_ready", {bus.w0_ready, bus.w1_ready, bus.r_ready}, 3'b111);

    // Single write then read-back
    bus.w0_valid = 1'b1; bus.w0_addr = 7'd5; bus.w0_data = 32'hA5A5A5A5;
    step();
    bus.w0_valid = 1'b0;
    chk("wr_lat_a1", wr0_en, 0);
    step();
    chk("wr_lat_en", wr0_en, 1);
    chk("wr_lat_addr", wr0_addr, 7'd5);
    chk("wr_lat_data", wr0_data, 32'hA5A5A5A5);
    step();
    chk("wr_idle_en", wr0_en, 0);
    chk("wr_hold_addr", wr0_addr, 7'd5);
    bus.r_valid = 1'b1; bus.r_addr = 7'd5;
    step();
    bus.r_valid = 1'b0;
    step();
    chk("rd_lat_en", rd0_en, 1);
    chk("rd_lat_addr", rd0_addr, 7'd5);
    step();
    chk("rd_lat_resp_early", bus.resp_valid, 0);
    step();
    chk("rd_lat_resp_valid", bus.resp_valid, 1);
    chk("rd_lat_resp_data", bus.resp_data, 32'hA5A5A5A5);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    chk("resp_popped", bus.resp_valid, 0);

    // Dual write to one address: port 1 must be the surviving value
    bus.w0_valid = 1'b1; bus.w0_addr = 7'd9; bus.w0_data = 32'h11;
    bus.w1_valid = 1'b1; bus.w1_addr = 7'd9; bus.w1_data = 32'h22;
    step();
    bus.w0_valid = 1'b0; bus.w1_valid = 1'b0;
    step();
`ifdef LVT_FE_COLLISION_SERIALIZE_EN
    chk("coll_wr0_first", {wr0_en, wr1_en}, 2'b10);
    step();
    chk("coll_wr1_next", {wr0_en, wr1_en}, 2'b01);
    chk("coll_wr1_addr", wr1_addr, 7'd9);
`else
    chk("dual_en", {wr0_en, wr1_en}, 2'b11);
    chk("dual_addr", {wr0_addr, wr1_addr}, {7'd9, 7'd9});
    chk("dual_data", {wr0_data, wr1_data}, {32'h11, 32'h22});
`endif
    repeat (2) step();
    bus.r_valid = 1'b1; bus.r_addr = 7'd9;
    step();
    bus.r_valid = 1'b0;
    repeat (3) step();
    chk("dual_resp_valid", bus.resp_valid, 1);
    chk("dual_resp_data", bus.resp_data, 32'h22);
    bus.resp_ready = 1'b1;
    step();

    // Continuous reads and writes: one grant per cycle, alternating
    bus.w0_valid = 1'b1; bus.w0_addr = 7'd30; bus.w0_data = 32'h33;
    bus.r_valid = 1'b1;  bus.r_addr = 7'd20;
    repeat (3) step();
    mon_alt = 1'b1;
    repeat (10) step();
    mon_alt = 1'b0;
    bus.w0_valid = 1'b0; bus.r_valid = 1'b0;
    repeat (20) step();
    chk("alt_gaps", alt_gaps, 0);
    chk("alt_repeats", alt_repeats, 0);
    chk("alt_drained", bus.resp_valid, 0);

    // Response back-pressure: credit limits issued reads to RESP_DEPTH
    for (int i = 0; i < 8; i++) push_w0(7'(40 + i), 32'h100 + i);
    repeat (10) step();
    bus.resp_ready = 1'b0;
    rd_base = rd_issued;
    for (int i = 0; i < 8; i++) push_r(7'(40 + i));
    repeat (6) step();
    chk("bp_issued", rd_issued - rd_base, 4);
    chk("bp_resp_valid", bus.resp_valid, 1);
    chk("bp_r_ready", bus.r_ready, 0);
    bus.resp_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 60 && got < 8; t++) begin
      if (bus.resp_valid) begin
        chk($sformatf("bp_order%0d", got), bus.resp_data, 32'h100 + got);
        got++;
      end
      step();
    end
    chk("bp_resp_count", got, 8);

    // Write FIFO fills while reads take every other grant
    mon_log = 1'b1;
    bus.r_valid = 1'b1; bus.r_addr = 7'd0;
    saw_full = 1'b0;
    nxt = 0;
    for (int t = 0; t < 40 && !saw_full; t++) begin
      bus.w0_valid = 1'b1; bus.w0_addr = 7'd60; bus.w0_data = 32'h500 + nxt;
      if (bus.w0_ready) begin
        wexp.push_back(32'h500 + nxt);
        nxt++;
      end else saw_full = 1'b1;
      step();
    end
    bus.w0_valid = 1'b0; bus.r_valid = 1'b0;
    repeat (20) step();
    mon_log = 1'b0;
    chk("fill_saw_full", saw_full, 1);
    chk("fill_log_size", wr0_log.size(), wexp.size());
    for (int i = 0; i < wexp.size() && i < wr0_log.size(); i++)
      chk($sformatf("fill_order%0d", i), wr0_log[i], wexp[i]);

    // Reset with a read in flight: returning data is dropped
    bus.r_valid = 1'b1; bus.r_addr = 7'd40;
    step();
    bus.r_valid = 1'b0;
    step();
    chk("mid_rst_rd_en", rd0_en, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {wr0_en, wr1_en, rd0_en}, 0);
    chk("mid_rst_ready", {bus.w0_ready, bus.w1_ready, bus.r_ready}, 0);
    step();
    #3 rst_n = 1'b1;
    hits = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (bus.resp_valid || wr0_en || wr1_en || rd0_en) hits++;
    end
    chk("mid_rst_quiet", hits, 0);
    chk("mid_rst_ready_back", {bus.w0_ready, bus.w1_ready, bus.r_ready}, 3'b111);
    chk("no_rd_wr_overlap", collisions, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
